// File: rtl/blackjack_round_ctrl_pkg.sv
// Shared game definitions: player commands, round outcomes, FSM states,
// default game thresholds and the card-rank to point-value mapping.
package blackjack_round_ctrl_pkg;

   localparam int DEALER_STAND_DEF = 17;
   localparam int BLACKJACK_DEF    = 21;
   localparam int SCORE_W          = 5;
   localparam int RANK_W           = 4;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      HIT   = 2'd1,
      STAND = 2'd2
   } gameCommand;

   typedef enum logic [1:0] {
      NO_RESULT = 2'd0,
      WIN       = 2'd1,
      LOSE      = 2'd2,
      PUSH      = 2'd3
   } gameResult;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      DEAL        = 3'd1,
      PLAYER_TURN = 3'd2,
      PLAYER_DRAW = 3'd3,
      DEALER_TURN = 3'd4,
      DEALER_DRAW = 3'd5,
      COMPARE     = 3'd6,
      RESULT      = 3'd7
   } round_state_t;

   // Ace counts 1 here (the soft +10 is applied by the hand), faces count 10,
   // and the unused rank codes 0/14/15 contribute nothing.
   function automatic logic [SCORE_W-1:0] card_value(input logic [RANK_W-1:0] rank);
      logic [SCORE_W-1:0] v;
      if (rank == 4'd0 || rank > 4'd13) begin
         v = '0;
      end else if (rank > 4'd10) begin
         v = SCORE_W'(10);
      end else begin
         v = SCORE_W'(rank);
      end
      return v;
   endfunction

endpackage

// File: rtl/blackjack_round_ctrl_hand_score.sv
// One blackjack hand: saturating hard total, ace flag and best score.
module hand_score
   import blackjack_round_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               capture,
   input  logic [RANK_W-1:0]  card_rank,
   output logic [SCORE_W-1:0] hard,
   output logic               ace,
   output logic [SCORE_W-1:0] best
);

   // Hard total pins at all-ones instead of wrapping so a bust stays a bust.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   // Accumulate the captured card; clear empties the hand for a new round.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hard <= '0;
         ace  <= 1'b0;
      end else if (clear) begin
         hard <= '0;
         ace  <= 1'b0;
      end else if (capture) begin
         hard <= sat_add(hard, card_value(card_rank));
         if (card_rank == RANK_W'(1)) begin
            ace <= 1'b1;
         end
      end
   end

   // One ace may count 11 whenever that does not push the hand past 21.
   always_comb begin
      best = hard;
      if (ace && hard <= SCORE_W'(11)) begin
         best = hard + SCORE_W'(10);
      end
   end

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals, runs player and dealer turns against a
// card-request handshake, and resolves the round outcome.
module blackjack_round_ctrl
   import blackjack_round_ctrl_pkg::*;
#(
   parameter int DEALER_STAND = DEALER_STAND_DEF,
   parameter int BLACKJACK    = BLACKJACK_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               ready,
   input  gameCommand         command,
   output logic               turnIndicator,
   output logic               card_req,
   input  logic               card_valid,
   input  logic [RANK_W-1:0]  card_rank,
   output logic [SCORE_W-1:0] player_score,
   output logic [SCORE_W-1:0] dealer_score,
   output gameResult          result,
   output logic               done
);

   localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(BLACKJACK);
   localparam logic [SCORE_W-1:0] STAND_AT = SCORE_W'(DEALER_STAND);

   round_state_t       state, state_next;
   logic [1:0]         deal_cnt, deal_cnt_next;
   logic               armed, armed_next;
   logic               settle, settle_next;
   gameResult          result_next;
   logic               clear_hands;
   logic               take_card;
   logic               player_cap, dealer_cap;
   logic [SCORE_W-1:0] player_hard, dealer_hard;
   logic               player_ace, dealer_ace;
   logic               unused_hand_detail;

   // Bust on either side decides first, otherwise the higher best score wins.
   function automatic gameResult outcome(input logic [SCORE_W-1:0] p,
                                         input logic [SCORE_W-1:0] d);
      if (p > TARGET) return LOSE;
      if (d > TARGET) return WIN;
      if (p > d)      return WIN;
      if (p < d)      return LOSE;
      return PUSH;
   endfunction

   hand_score u_player (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_hands),
      .capture   (player_cap),
      .card_rank (card_rank),
      .hard      (player_hard),
      .ace       (player_ace),
      .best      (player_score)
   );

   hand_score u_dealer (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_hands),
      .capture   (dealer_cap),
      .card_rank (card_rank),
      .hard      (dealer_hard),
      .ace       (dealer_ace),
      .best      (dealer_score)
   );

   // The round logic only ever looks at best scores.
   assign unused_hand_detail = ^{player_hard, player_ace, dealer_hard, dealer_ace};

   // Output decode and card routing. settle marks the cycle after a capture,
   // which drops card_req and lets the updated score be examined.
   always_comb begin
      card_req      = 1'b0;
      turnIndicator = (state == PLAYER_TURN);
      done          = (state == RESULT);
      if (state == DEAL || state == PLAYER_DRAW || state == DEALER_DRAW) begin
         card_req = !settle;
      end
      take_card  = card_req && card_valid;
      player_cap = take_card && (state == PLAYER_DRAW || (state == DEAL && !deal_cnt[0]));
      dealer_cap = take_card && (state == DEALER_DRAW || (state == DEAL &&  deal_cnt[0]));
   end

   // Next-state logic; a released button (ready low) re-arms command acceptance.
   always_comb begin
      state_next    = state;
      deal_cnt_next = deal_cnt;
      armed_next    = armed;
      settle_next   = settle;
      result_next   = result;
      clear_hands   = 1'b0;
      if (!ready) begin
         armed_next = 1'b1;
      end
      case (state)
         IDLE, RESULT: begin
            if (start) begin
               clear_hands   = 1'b1;
               result_next   = NO_RESULT;
               deal_cnt_next = 2'd0;
               settle_next   = 1'b0;
               state_next    = DEAL;
            end
         end
         DEAL: begin
            if (settle) begin
               settle_next = 1'b0;
               // Counter wrapped back to zero: all four cards are in.
               if (deal_cnt == 2'd0) begin
                  if (player_score == TARGET || dealer_score == TARGET) begin
                     state_next = COMPARE;
                  end else begin
                     state_next = PLAYER_TURN;
                  end
               end
            end else if (take_card) begin
               settle_next   = 1'b1;
               deal_cnt_next = deal_cnt + 2'd1;
            end
         end
         PLAYER_TURN: begin
            if (armed && ready && command == HIT) begin
               armed_next = 1'b0;
               state_next = PLAYER_DRAW;
            end else if (armed && ready && command == STAND) begin
               armed_next = 1'b0;
               state_next = DEALER_TURN;
            end
         end
         PLAYER_DRAW: begin
            if (settle) begin
               settle_next = 1'b0;
               if (player_score > TARGET) begin
                  state_next = COMPARE;
               end else if (player_score == TARGET) begin
                  state_next = DEALER_TURN;
               end else begin
                  state_next = PLAYER_TURN;
               end
            end else if (take_card) begin
               settle_next = 1'b1;
            end
         end
         DEALER_TURN: begin
            state_next = (dealer_score < STAND_AT) ? DEALER_DRAW : COMPARE;
         end
         DEALER_DRAW: begin
            if (settle) begin
               settle_next = 1'b0;
               state_next  = DEALER_TURN;
            end else if (take_card) begin
               settle_next = 1'b1;
            end
         end
         COMPARE: begin
            result_next = outcome(player_score, dealer_score);
            state_next  = RESULT;
         end
         default: state_next = IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         deal_cnt <= 2'd0;
         armed    <= 1'b0;
         settle   <= 1'b0;
         result   <= NO_RESULT;
      end else begin
         state    <= state_next;
         deal_cnt <= deal_cnt_next;
         armed    <= armed_next;
         settle   <= settle_next;
         result   <= result_next;
      end
   end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Scoreboard bench for blackjack_round_ctrl: a shoe/deck model, a player
// model and a rules-level round model feeding an expectation queue.
`timescale 1ns/1ps
module tb_blackjack_round_ctrl;
   import blackjack_round_ctrl_pkg::*;

   localparam int BJ  = 21;
   localparam int DST = 17;

   logic       clk = 1'b0;
   logic       reset, start, ready, card_valid;
   gameCommand command;
   logic [3:0] card_rank;
   logic       turnIndicator, card_req, done;
   logic [4:0] player_score, dealer_score;
   gameResult  result;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int        ps;
      int        ds;
      gameResult res;
      int        cards;
      bit        natural;
   } exp_t;

   typedef struct {
      gameCommand cmd;
      int         hold;
   } dec_t;

   exp_t sb[$];
   dec_t dec_q[$];
   int   shoe_q[$];
   int   gen[$];
   int   cards_given = 0;
   int   turn_cycles = 0;
   bit   deck_hold = 1'b0;
   int   thr;
   int   hold_fixed;

   always #5 clk = ~clk;

   blackjack_round_ctrl #(.DEALER_STAND(DST), .BLACKJACK(BJ)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .ready         (ready),
      .command       (command),
      .turnIndicator (turnIndicator),
      .card_req      (card_req),
      .card_valid    (card_valid),
      .card_rank     (card_rank),
      .player_score  (player_score),
      .dealer_score  (dealer_score),
      .result        (result),
      .done          (done)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic int card_val(input int r);
      if (r == 1) return 1;
      if (r >= 2 && r <= 10) return r;
      if (r >= 11 && r <= 13) return 10;
      return 0;
   endfunction

   function automatic int best_of(input int cards[$]);
      int hard = 0;
      bit ace = 1'b0;
      foreach (cards[i]) begin
         hard += card_val(cards[i]);
         if (hard > 31) hard = 31;
         if (cards[i] == 1) ace = 1'b1;
      end
      return (ace && hard <= 11) ? hard + 10 : hard;
   endfunction

   // Deck: answers card_req after a random delay, pulses junk when not asked.
   initial begin
      int delay = 0;
      bit presented = 1'b0;
      card_valid = 1'b0;
      card_rank  = 4'd0;
      forever begin
         @(negedge clk);
         if (card_valid) begin
            if (presented) check("req_low_after_capture", int'(card_req), 0);
            card_valid = 1'b0;
            presented  = 1'b0;
         end else if (card_req && !deck_hold) begin
            if (delay == 0) begin
               card_valid = 1'b1;
               presented  = 1'b1;
               card_rank  = (shoe_q.size() > 0) ? 4'(shoe_q.pop_front()) : 4'd0;
               cards_given++;
               delay = $urandom_range(0, 3);
            end else begin
               delay--;
            end
         end else if (!card_req && $urandom_range(0, 5) == 0) begin
            card_valid = 1'b1;
            presented  = 1'b0;
            card_rank  = 4'($urandom_range(1, 13));
         end
      end
   end

   // Player: release, press, hold for a while, release.
   initial begin
      dec_t dc;
      ready   = 1'b0;
      command = NONE;
      forever begin
         @(negedge clk);
         if (turnIndicator && dec_q.size() > 0) begin
            dc      = dec_q.pop_front();
            ready   = 1'b0;
            command = NONE;
            @(negedge clk);
            ready   = 1'b1;
            command = dc.cmd;
            repeat (dc.hold) @(negedge clk);
            ready   = 1'b0;
            command = NONE;
         end else if (!turnIndicator) begin
            ready   = 1'($urandom_range(0, 1));
            command = gameCommand'($urandom_range(0, 2));
         end
      end
   end

   // Monitor: compare each finished round against the scoreboard head.
   initial begin
      exp_t e;
      bit done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (turnIndicator) turn_cycles++;
         if (done && !done_q) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1, expected no finished round");
            end else begin
               e = sb.pop_front();
               check("player_score", int'(player_score), e.ps);
               check("dealer_score", int'(dealer_score), e.ds);
               check("result", int'(result), int'(e.res));
               check("cards_dealt", cards_given, e.cards);
               check("turn_seen", int'(turn_cycles > 0), int'(!e.natural));
            end
         end
         done_q = done;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      dec_q.delete();
      shoe_q.delete();
   endtask

   task automatic pad_gen();
      while (gen.size() < 40) begin
         if ($urandom_range(0, 19) == 0) gen.push_back($urandom_range(0, 1) ? 0 : $urandom_range(14, 15));
         else gen.push_back($urandom_range(1, 13));
      end
   endtask

   // Play one round from gen/thr through the rules model, then drive the DUT.
   task automatic run_round();
      int   p[$];
      int   d[$];
      int   idx, ps, ds, n;
      bit   pbust;
      exp_t e;
      dec_t dc;
      pad_gen();
      dec_q.delete();
      shoe_q.delete();
      p = {gen[0], gen[2]};
      d = {gen[1], gen[3]};
      idx = 4;
      ps = best_of(p);
      ds = best_of(d);
      pbust = 1'b0;
      e.natural = (ps == BJ || ds == BJ);
      if (!e.natural) begin
         while (idx < gen.size()) begin
            dc.hold = (hold_fixed > 0) ? hold_fixed : $urandom_range(1, 5);
            if (ps >= thr) begin
               dc.cmd = STAND;
               dec_q.push_back(dc);
               break;
            end
            dc.cmd = HIT;
            dec_q.push_back(dc);
            p.push_back(gen[idx]);
            idx++;
            ps = best_of(p);
            if (ps > BJ) begin
               pbust = 1'b1;
               break;
            end
            if (ps == BJ) break;
         end
         if (!pbust) begin
            while (ds < DST && idx < gen.size()) begin
               d.push_back(gen[idx]);
               idx++;
               ds = best_of(d);
            end
         end
      end
      if (pbust)        e.res = LOSE;
      else if (ds > BJ) e.res = WIN;
      else if (ps > ds) e.res = WIN;
      else if (ps < ds) e.res = LOSE;
      else              e.res = PUSH;
      e.ps = ps;
      e.ds = ds;
      e.cards = idx;
      sb.push_back(e);
      for (int i = 0; i < idx; i++) shoe_q.push_back(gen[i]);

      @(negedge clk);
      cards_given = 0;
      turn_cycles = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_done_low", int'(done), 0);
      check("start_result_clear", int'(result), int'(NO_RESULT));
      check("start_player_clear", int'(player_score), 0);
      check("start_dealer_clear", int'(dealer_score), 0);
      check("start_first_req", int'(card_req), 1);

      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         if (turnIndicator && !done && $urandom_range(0, 15) == 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
         end
      end
      check("round_done", int'(done), 1);
      if (!done) begin
         do_reset();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      hold_fixed = 0;
      repeat (2) @(negedge clk);
      check("rst_card_req", int'(card_req), 0);
      check("rst_turn", int'(turnIndicator), 0);
      check("rst_player", int'(player_score), 0);
      check("rst_dealer", int'(dealer_score), 0);
      check("rst_result", int'(result), int'(NO_RESULT));
      check("rst_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Player 10,7 vs dealer 9,8, player stands on 17.
      gen = {10, 9, 7, 8};  thr = 17; run_round();
      // Player ace+king natural vs dealer 5,6.
      gen = {1, 5, 13, 6};  thr = 17; run_round();
      // Player 10,6 hits once with a long-held button and busts on a 10.
      gen = {10, 9, 6, 7, 10}; thr = 17; hold_fixed = 10; run_round();
      hold_fixed = 0;
      // Dealer soft 17 stands; player 19 wins.
      gen = {10, 1, 9, 6};  thr = 19; run_round();
      // 18 vs 18 push, then the next round restarts straight from RESULT.
      gen = {10, 10, 8, 8}; thr = 18; run_round();

      // Reset in the middle of a player draw with no card presented.
      gen = {10, 5, 6, 9};
      shoe_q.delete();
      for (int i = 0; i < 4; i++) shoe_q.push_back(gen[i]);
      dec_q.delete();
      dec_q.push_back('{cmd: HIT, hold: 1});
      @(negedge clk);
      cards_given = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!turnIndicator && n < 500) begin
         @(negedge clk);
         n++;
      end
      deck_hold = 1'b1;
      n = 0;
      while (!card_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("draw_req_high", int'(card_req), 1);
      check("draw_player_16", int'(player_score), 16);
      reset = 1'b1;
      #1;
      check("midrst_card_req", int'(card_req), 0);
      check("midrst_turn", int'(turnIndicator), 0);
      check("midrst_player", int'(player_score), 0);
      check("midrst_dealer", int'(dealer_score), 0);
      check("midrst_result", int'(result), int'(NO_RESULT));
      check("midrst_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      deck_hold = 1'b0;
      dec_q.delete();
      shoe_q.delete();
      repeat (2) @(negedge clk);

      // Randomized rounds.
      for (int r = 0; r < 40; r++) begin
         gen.delete();
         thr = $urandom_range(12, 21);
         run_round();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
